// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the synchronous instruction memory
// with byte-stream program loader.
package imem_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // ADDI x0,x0,0
  localparam logic [31:0] IMEM_NOP_INSTR = 32'h0000_0013;

  // Widest word the parity helper accepts
  localparam int unsigned PAR_MAX_W = 64;

  // Even parity: the stored bit makes the total count of ones even
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles little-endian bytes into a DATA_W word.
// o_word_c / o_word_done_c are combinational so the word can be written on
// the same edge its last byte is accepted.
module imem_byte_packer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word_c,
  output logic              o_word_done_c
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [BCNT_W-1:0] r_byte_cnt;
  logic              w_last;

  assign w_last        = (r_byte_cnt == BCNT_W'(BYTES - 1));
  assign o_word_done_c = i_byte_valid && w_last;

  // Byte position within the word being assembled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= '0;
    end else if (i_byte_valid) begin
      r_byte_cnt <= w_last ? '0 : r_byte_cnt + BCNT_W'(1);
    end
  end

  generate
    if (BYTES == 1) begin : g_single
      assign o_word_c = i_byte;
    end else begin : g_shift
      localparam int unsigned SH_W = DATA_W - 8;
      logic [SH_W-1:0] r_shift;

      // Bytes enter at the top and drift down, so the first byte ends at the LSB
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_shift <= '0;
        end else if (i_byte_valid) begin
          r_shift <= (r_shift >> 8) | (SH_W'(i_byte) << (SH_W - 8));
        end
      end

      assign o_word_c = {i_byte, r_shift};
    end
  endgenerate

endmodule

// File: rtl/imem_sync_loader.sv
// imem_sync_loader: synchronous instruction memory with one-cycle registered
// fetch and a run-time byte-stream program loader.
// Optional feature macro: IMEM_PARITY_EN adds a per-word even-parity bit and
// the fetch_parity_err output.
module imem_sync_loader
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(IMEM_NOP_INSTR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_valid,
  output logic [DATA_W-1:0]        fetch_instr,
  output logic                     fetch_fault,
`ifdef IMEM_PARITY_EN
  output logic                     fetch_parity_err,
`endif
  input  logic                     load_start,
  input  logic [$clog2(DEPTH)-1:0] load_base,
  input  logic [$clog2(DEPTH):0]   load_count,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  output logic                     load_ready,
  output logic                     load_busy,
  output logic                     load_done
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];

  load_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_wr_idx, w_wr_idx_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_nxt;
  logic              r_load_ready, r_load_busy, r_load_done;
  logic              w_ready_nxt, w_busy_nxt, w_done_nxt;
  logic              w_clear, w_wr_en, w_accept;
  logic [DATA_W-1:0] w_word;
  logic              w_word_done;

  logic [ADDR_W-1:0] w_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_misaligned, w_oob, w_fault, w_fetch_go;
  logic              r_fetch_valid, r_fetch_fault;
  logic [DATA_W-1:0] r_fetch_instr;

  assign w_accept = load_valid && r_load_ready;

  imem_byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .i_clk         (clk),
    .i_rst_n       (rst),
    .i_clear       (w_clear),
    .i_byte_valid  (w_accept),
    .i_byte        (load_byte),
    .o_word_c      (w_word),
    .o_word_done_c (w_word_done)
  );

  // Loader state and load bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_wr_idx     <= '0;
      r_count      <= '0;
      r_word_cnt   <= '0;
      r_load_ready <= 1'b0;
      r_load_busy  <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_idx     <= w_wr_idx_nxt;
      r_count      <= w_count_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_load_ready <= w_ready_nxt;
      r_load_busy  <= w_busy_nxt;
      r_load_done  <= w_done_nxt;
    end
  end

  // Loader next-state, write strobe and next values of the status outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_idx_nxt   = r_wr_idx;
    w_count_nxt    = r_count;
    w_word_cnt_nxt = r_word_cnt;
    w_clear        = 1'b0;
    w_wr_en        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_clear        = 1'b1;
          // Fold an out-of-range base back into the array for non-power-of-two depths
          w_wr_idx_nxt   = (load_base >= IDX_W'(DEPTH)) ? load_base - IDX_W'(DEPTH) : load_base;
          w_count_nxt    = load_count;
          w_word_cnt_nxt = '0;
          w_state_nxt    = (load_count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_word_done) begin
          w_wr_en        = 1'b1;
          w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
          w_wr_idx_nxt   = (r_wr_idx >= IDX_W'(DEPTH - 1)) ? '0 : r_wr_idx + IDX_W'(1);
          if ((r_word_cnt + CNT_W'(1)) == r_count) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_ready_nxt = (w_state_nxt == ST_LOAD);
    w_busy_nxt  = (w_state_nxt == ST_LOAD);
    w_done_nxt  = (w_state_nxt == ST_DONE);
  end

  // Memory array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_idx] <= w_word;
    end
  end

  assign w_idx        = fetch_addr >> OFF_W;
  assign w_rd_idx     = IDX_W'(w_idx);
  assign w_misaligned = |(fetch_addr & ADDR_W'(BYTES - 1));
  assign w_oob        = (w_idx >= ADDR_W'(DEPTH));
  assign w_fault      = w_misaligned || w_oob;
  assign w_fetch_go   = fetch_req && (r_state == ST_IDLE);

  // Registered fetch port; instr holds its last value when no fetch is serviced
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_instr <= '0;
    end else begin
      r_fetch_valid <= w_fetch_go;
      r_fetch_fault <= w_fetch_go && w_fault;
      if (w_fetch_go) begin
        r_fetch_instr <= w_fault ? NOP_INSTR : r_mem[w_rd_idx];
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic r_par_mem [DEPTH];
  logic r_parity_err;

  // Parity bit stored alongside each written word
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_par_mem[r_wr_idx] <= even_parity(PAR_MAX_W'(w_word));
    end
  end

  // Parity check on serviced, non-faulted fetches only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_fetch_go && !w_fault &&
                      (even_parity(PAR_MAX_W'(r_mem[w_rd_idx])) != r_par_mem[w_rd_idx]);
    end
  end

  assign fetch_parity_err = r_parity_err;
`endif

  assign fetch_valid = r_fetch_valid;
  assign fetch_instr = r_fetch_instr;
  assign fetch_fault = r_fetch_fault;
  assign load_ready  = r_load_ready;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;

endmodule

// File: tb/tb_imem_sync_loader.sv
// tb_imem_sync_loader: randomized scoreboard bench for imem_sync_loader.
// Define IMEM_PARITY_EN for both files to exercise the parity option.
module tb_imem_sync_loader;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_fault;
  logic              load_start;
  logic [9:0]        load_base;
  logic [10:0]       load_count;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
`ifdef IMEM_PARITY_EN
  logic              fetch_parity_err;
`endif

  imem_sync_loader #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_valid      (fetch_valid),
    .fetch_instr      (fetch_instr),
    .fetch_fault      (fetch_fault),
`ifdef IMEM_PARITY_EN
    .fetch_parity_err (fetch_parity_err),
`endif
    .load_start       (load_start),
    .load_base        (load_base),
    .load_count       (load_count),
    .load_valid       (load_valid),
    .load_byte        (load_byte),
    .load_ready       (load_ready),
    .load_busy        (load_busy),
    .load_done        (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
    logic        par;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] model_mem [DEPTH];
  logic        model_bad [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: word-indexed array, fault when misaligned or past the last word
  function automatic exp_t model_fetch(input logic [31:0] addr);
    exp_t e;
    e.fault = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
    e.instr = NOP;
    e.par   = 1'b0;
    if (!e.fault) begin
      e.instr = model_mem[addr / 4];
      e.par   = model_bad[addr / 4];
    end
    return e;
  endfunction

  // Monitor: every presented fetch result must match the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1 && fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL fetch_unexpected: got fetch_valid=1 instr=%h, required no result", fetch_instr);
      end else begin
        e = exp_q.pop_front();
        check("fetch_instr", fetch_instr, e.instr);
        check("fetch_fault", 32'(fetch_fault), 32'(e.fault));
`ifdef IMEM_PARITY_EN
        check("fetch_parity_err", 32'(fetch_parity_err), 32'(e.par));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    exp_q.push_back(model_fetch(addr));
    tick();
    fetch_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned kind;
    kind = $urandom_range(9, 0);
    if (kind < 7) return 32'($urandom_range(DEPTH - 1, 0)) * 4;
    if (kind == 7) return 32'($urandom_range(DEPTH - 1, 0)) * 4 + 32'($urandom_range(3, 1));
    return $urandom | 32'h0000_1000;
  endfunction

  task automatic fetch_burst(input int n);
    fetch_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      fetch_addr = rand_addr();
      exp_q.push_back(model_fetch(fetch_addr));
      tick();
    end
    fetch_req = 1'b0;
  endtask

  // Streams byte_q into [base, base+count) and updates the model word by word
  task automatic do_load(input int base, input int count, input int gap_max,
                         input logic with_fetch, input logic [31:0] faddr,
                         input logic drop_fetch);
    logic [31:0] word;
    load_start = 1'b1;
    load_base  = 10'(base);
    load_count = 11'(count);
    if (with_fetch) begin
      fetch_req  = 1'b1;
      fetch_addr = faddr;
      exp_q.push_back(model_fetch(faddr));
    end
    tick();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    if (count == 0) begin
      check("done_count0", 32'(load_done), 32'd1);
      check("ready_count0", 32'(load_ready), 32'd0);
      tick();
      check("done_count0_clear", 32'(load_done), 32'd0);
      return;
    end
    check("load_ready_rise", 32'(load_ready), 32'd1);
    check("load_busy_rise", 32'(load_busy), 32'd1);
    for (int w = 0; w < count; w++) begin
      word = '0;
      for (int b = 0; b < 4; b++) begin
        repeat (int'($urandom_range(gap_max, 0))) begin
          load_valid = 1'b0;
          tick();
        end
        load_valid = 1'b1;
        load_byte  = byte_q.pop_front();
        word       = word | (32'(load_byte) << (8 * b));
        if (drop_fetch && w == 0 && b == 1) begin
          fetch_req  = 1'b1;
          fetch_addr = rand_addr();
        end
        tick();
        if (drop_fetch && w == 0 && b == 1) begin
          fetch_req = 1'b0;
          check("drop_fetch_load", 32'(fetch_valid), 32'd0);
        end
      end
      model_mem[(base + w) % DEPTH] = word;
      model_bad[(base + w) % DEPTH] = 1'b0;
    end
    load_valid = 1'b0;
    check("load_done_pulse", 32'(load_done), 32'd1);
    check("load_ready_fall", 32'(load_ready), 32'd0);
    if (drop_fetch) begin
      fetch_req  = 1'b1;
      fetch_addr = rand_addr();
    end
    tick();
    if (drop_fetch) begin
      fetch_req = 1'b0;
      check("drop_fetch_done", 32'(fetch_valid), 32'd0);
    end
    check("load_done_clear", 32'(load_done), 32'd0);
    check("load_busy_clear", 32'(load_busy), 32'd0);
  endtask

  task automatic fill_bytes(input int n);
    for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = '0;
    load_start = 1'b0;
    load_base  = '0;
    load_count = '0;
    load_valid = 1'b0;
    load_byte  = '0;
    for (int i = 0; i < int'(DEPTH); i++) model_bad[i] = 1'b0;
    #1 rst = 1'b0;

    // Reset with a pending fetch request: everything reads 0
    repeat (3) begin
      @(negedge clk);
      check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
      check("rst_fetch_instr", fetch_instr, 32'd0);
      check("rst_load_ready", 32'(load_ready), 32'd0);
      check("rst_load_busy", 32'(load_busy), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
`ifdef IMEM_PARITY_EN
      check("rst_parity_err", 32'(fetch_parity_err), 32'd0);
`endif
    end
    tick();
    rst       = 1'b1;
    fetch_req = 1'b0;
    repeat (3) begin
      tick();
      check("idle_no_valid", 32'(fetch_valid), 32'd0);
    end

    // Fill the whole array so every later fetch has a known value
    fill_bytes(4 * DEPTH);
    do_load(0, DEPTH, 0, 1'b0, '0, 1'b0);

    // Directed program load
    byte_q = '{8'h93, 8'h82, 8'h22, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00};
    do_load(0, 2, 1, 1'b0, '0, 1'b0);
    check("model_word1", model_mem[1], 32'h0062_E233);
    check("model_word0", model_mem[0], 32'h0022_8293);
    do_fetch(32'h4);
    do_fetch(32'h0);

    // Misaligned and out-of-range fetches
    do_fetch(32'h6);
    do_fetch(32'h1000);

    // Write index wraps from the last word to word 0
    fill_bytes(8);
    do_load(DEPTH - 1, 2, 1, 1'b0, '0, 1'b1);
    do_fetch(32'hFFC);
    do_fetch(32'h0);

    // Zero-length load, then load_start together with a fetch of the target
    do_load(5, 0, 0, 1'b0, '0, 1'b0);
    fill_bytes(4);
    do_load(7, 1, 1, 1'b1, 32'h1C, 1'b0);
    do_fetch(32'h1C);

    // Reset in the middle of a word: partial word discarded, target kept
    load_start = 1'b1;
    load_base  = 10'd9;
    load_count = 11'd1;
    tick();
    load_start = 1'b0;
    repeat (2) begin
      load_valid = 1'b1;
      load_byte  = 8'($urandom);
      tick();
    end
    load_valid = 1'b0;
    check("midload_busy", 32'(load_busy), 32'd1);
    fetch_req  = 1'b1;
    fetch_addr = 32'h24;
    tick();
    fetch_req = 1'b0;
    check("busy_fetch_dropped", 32'(fetch_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("midload_rst_busy", 32'(load_busy), 32'd0);
    check("midload_rst_ready", 32'(load_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    do_fetch(32'h24);
    fill_bytes(4);
    do_load(9, 1, 0, 1'b0, '0, 1'b0);
    do_fetch(32'h24);

`ifdef IMEM_PARITY_EN
    // Corrupt one stored bit behind the parity bit's back
    dut.r_mem[3] = dut.r_mem[3] ^ 32'h0000_0100;
    model_mem[3] = model_mem[3] ^ 32'h0000_0100;
    model_bad[3] = 1'b1;
    do_fetch(32'hC);
    do_fetch(32'h8);
`endif

    // Randomized mix of loads and fetch bursts
    repeat (40) begin
      if ($urandom_range(1, 0) == 0) begin
        int base;
        int count;
        base  = int'($urandom_range(DEPTH - 1, 0));
        count = int'($urandom_range(6, 0));
        fill_bytes(4 * count);
        do_load(base, count, int'($urandom_range(2, 0)), 1'($urandom), rand_addr(),
                (count > 0) ? 1'($urandom) : 1'b0);
      end else begin
        fetch_burst(int'($urandom_range(5, 1)));
      end
      do_fetch(rand_addr());
    end

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_sync_loader.md
# imem_sync_loader

Parametrised, synchronous instruction memory for the single-cycle RISC-V core with a built-in byte-stream program loader. It replaces the combinational ROM that is preloaded at elaboration. Fetches are registered with one-cycle latency and a valid flag, and misaligned or out-of-range fetches are flagged. A host, debug UART or testbench streams a program into any word range at run time. The block sits between the PC/fetch logic and the decoder.

## Interface
- `DATA_W`, 32: instruction width in bits; must be a multiple of 8.
- `DEPTH`, 1024: number of words.
- `ADDR_W`, 32: byte-address width of `fetch_addr`.
- `NOP_INSTR`, 32'h00000013: value returned on a faulted fetch (ADDI x0,x0,0).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `fetch_req`, in, 1: fetch request.
- `fetch_addr`, in, ADDR_W: byte address of the instruction.
- `fetch_valid`, out, 1: `fetch_instr` is valid this cycle.
- `fetch_instr`, out, DATA_W: fetched word.
- `fetch_fault`, out, 1: the fetch was misaligned or out of range.
- `load_start`, in, 1: pulse that begins a program load.
- `load_base`, in, clog2(DEPTH): first word index of the load.
- `load_count`, in, clog2(DEPTH)+1: number of words to load.
- `load_valid`, in, 1: `load_byte` is valid.
- `load_byte`, in, 8: program byte, little-endian within each word.
- `load_ready`, out, 1: the block accepts bytes.
- `load_busy`, out, 1: a load is in progress.
- `load_done`, out, 1: one-cycle pulse when a load completes.
- `fetch_parity_err`, out, 1: present only when IMEM_PARITY_EN is defined.

## Operation
- **Word index:** `fetch_addr[ADDR_W-1:log2(DATA_W/8)]`.
  - Fault if the low byte-offset bits are nonzero (misaligned) or the index is >= DEPTH.
  - On a fault, `fetch_instr` = NOP_INSTR and `fetch_fault` = 1.
- **Loader FSM states:** IDLE, LOAD, DONE.
- **IDLE:**
  - `fetch_req` is serviced.
  - `load_start` latches `load_base` and `load_count`, clears the byte counter and the word counter, and moves to LOAD.
  - `load_count` = 0 goes straight to DONE with no writes.
- **LOAD:**
  - `load_ready` = 1 and `load_busy` = 1.
  - A byte is accepted when `load_valid` && `load_ready`.
  - Bytes fill the word from the LSB up.
  - On the edge the last byte of a word is accepted, the word is written to `mem[(base+n) mod DEPTH]`, so the write index wraps.
  - After `load_count` words, move to DONE.
- **DONE:** `load_done` = 1 for one cycle, then IDLE.
- **Fetch during LOAD or DONE:** the request is dropped; `fetch_valid` = 0 on the next cycle.
- **`load_start` outside IDLE:** ignored.
- **`load_start` and `fetch_req` in the same IDLE cycle:** both take effect; the fetch returns pre-load contents.
- **Reset asserted:**
  - FSM goes to IDLE and the partial word is discarded.
  - Words already written are retained; memory contents are never reset.

## Timing
- **Fetch latency:** a request at edge N produces `fetch_valid`, `fetch_instr` and `fetch_fault` after edge N+1, held for one cycle. Back-to-back requests give one result per cycle.
- **Without a request:** `fetch_valid` = 0 and `fetch_instr` holds its last value.
- **Reset values:**
  - `fetch_valid`, `fetch_fault`, `load_ready`, `load_busy`, `load_done`, `fetch_parity_err` = 0.
  - `fetch_instr` = 0.
  - FSM = IDLE.
- **Load latency:** `load_ready` rises the cycle after the `load_start` edge. `load_done` is asserted the cycle after the final byte is accepted.

## Configuration
- **IMEM_PARITY_EN defined:**
  - Each entry stores an extra even-parity bit, computed at write.
  - On each valid non-faulted fetch, `fetch_parity_err` = 1 if the stored parity mismatches.
  - On a faulted fetch, `fetch_parity_err` = 0.
- **IMEM_PARITY_EN undefined:** the port is absent and no parity storage is built.

## Structure
- **Package `imem_pkg`:**
  - the FSM state enum (IDLE/LOAD/DONE);
  - the default NOP_INSTR constant;
  - the parity function.
- **Sub-module `imem_byte_packer`:** byte counter plus shift register. It outputs the assembled word and a `word_done` strobe.

## Test plan
- **Reset:** hold `rst`=0 with `fetch_req`=1. All outputs must be 0; after release `fetch_valid` stays 0 until the first request.
- **Load then fetch:** `load_start` with base=0, count=2, bytes 93 82 22 00 33 E2 62 00.
  - `load_done` pulses the cycle after the 8th byte.
  - Fetch 0x4 returns 0x0062E233 one cycle later; fetch 0x0 returns 0x00228293.
- **Faults:**
  - Fetch 0x6 gives fault=1, instr=0x00000013.
  - Fetch 0x1000 with DEPTH=1024 gives fault=1, instr=0x00000013.
- **Wrap:** base=1023, count=2. Words are written to index 1023 and index 0; fetches of 0xFFC and 0x0 return them.
- **Reset mid-load:**
  - Drive 2 bytes, then pulse `rst` low. The FSM is IDLE and the target word is unchanged.
  - A fetch issued while `load_busy`=1 gives `fetch_valid`=0.
- **Parity (IMEM_PARITY_EN only):** force one stored bit to flip, then fetch that word. Required: `fetch_parity_err`=1 with `fetch_valid`=1; clean words read 0.
